// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the SNN timestep controller: default widths and FSM encoding.
package snn_ctrl_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_TIMER_WIDTH = 5;
  localparam int DEF_CYCLE_WIDTH = 8;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_CLEAR   = 3'd1;
  localparam state_t S_COMPUTE = 3'd2;
  localparam state_t S_SAMPLE  = 3'd3;
  localparam state_t S_NEXT    = 3'd4;
  localparam state_t S_READOUT = 3'd5;

endpackage

// File: rtl/snn_cycle_counter.sv
// Loadable down-counter with a zero flag; times the COMPUTE window of each timestep.
module snn_cycle_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/snn_timestep_controller.sv
// Sequences a spiking-inference run: clear, T x (compute C cycles, sample, flush), then readout handshake.
module snn_timestep_controller
  import snn_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int TIMER_WIDTH = DEF_TIMER_WIDTH,
  parameter int CYCLE_WIDTH = DEF_CYCLE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [TIMER_WIDTH-1:0] cfg_timesteps,
  input  logic [CYCLE_WIDTH-1:0] cfg_compute_cycles,
  input  logic [DATA_WIDTH-1:0]  cfg_threshold,
  output logic [DATA_WIDTH-1:0]  threshold_out,
  output logic                   acc_clr_n,
  output logic                   array_en,
  output logic                   array_flush,
  output logic                   spike_sample,
  output logic [TIMER_WIDTH-1:0] timestep,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  state_t                 state_q, state_d;
  logic [TIMER_WIDTH-1:0] t_cfg_q, t_cfg_d;
  logic [CYCLE_WIDTH-1:0] c_cfg_q, c_cfg_d;
  logic [DATA_WIDTH-1:0]  thr_q, thr_d;
  logic [TIMER_WIDTH-1:0] timestep_q, timestep_d;

  logic acc_clr_n_q, acc_clr_n_d;
  logic array_en_q, array_en_d;
  logic array_flush_q, array_flush_d;
  logic spike_sample_q, spike_sample_d;
  logic out_valid_q, out_valid_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic                   cyc_load;
  logic                   cyc_dec;
  logic                   cyc_zero;
  logic [CYCLE_WIDTH-1:0] cyc_load_val;

  // C==0 behaves as C==1, so both reload the counter with 0 (one compute cycle).
  assign cyc_load     = (state_q == S_CLEAR) || (state_q == S_NEXT);
  assign cyc_dec      = (state_q == S_COMPUTE);
  assign cyc_load_val = (c_cfg_q == '0) ? '0 : (c_cfg_q - 1'b1);

  snn_cycle_counter #(
    .WIDTH (CYCLE_WIDTH)
  ) u_cycle_counter (
    .clk      (clk),
    .rstn     (rstn),
    .load     (cyc_load),
    .dec      (cyc_dec),
    .load_val (cyc_load_val),
    .zero     (cyc_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      t_cfg_q        <= '0;
      c_cfg_q        <= '0;
      thr_q          <= '0;
      timestep_q     <= '0;
      acc_clr_n_q    <= 1'b1;
      array_en_q     <= 1'b0;
      array_flush_q  <= 1'b0;
      spike_sample_q <= 1'b0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_cfg_q        <= t_cfg_d;
      c_cfg_q        <= c_cfg_d;
      thr_q          <= thr_d;
      timestep_q     <= timestep_d;
      acc_clr_n_q    <= acc_clr_n_d;
      array_en_q     <= array_en_d;
      array_flush_q  <= array_flush_d;
      spike_sample_q <= spike_sample_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    t_cfg_d    = t_cfg_q;
    c_cfg_d    = c_cfg_q;
    thr_d      = thr_q;
    timestep_d = timestep_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          t_cfg_d = cfg_timesteps;
          c_cfg_d = cfg_compute_cycles;
          thr_d   = cfg_threshold;
          if (cfg_timesteps != '0) begin
            state_d    = S_CLEAR;
            timestep_d = '0;
          end
        end
      end
      S_CLEAR:   state_d = S_COMPUTE;
      S_COMPUTE: if (cyc_zero) state_d = S_SAMPLE;
      S_SAMPLE: begin
        if (timestep_q == (t_cfg_q - 1'b1)) begin
          state_d = S_READOUT;
        end else begin
          state_d    = S_NEXT;
          timestep_d = timestep_q + 1'b1;
        end
      end
      S_NEXT:    state_d = S_COMPUTE;
      S_READOUT: if (out_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    acc_clr_n_d    = (state_d != S_CLEAR);
    array_en_d     = (state_d == S_COMPUTE);
    array_flush_d  = (state_d == S_NEXT);
    spike_sample_d = (state_d == S_SAMPLE);
    out_valid_d    = (state_d == S_READOUT);
    busy_d         = (state_d != S_IDLE);
    done_d         = ((state_q == S_READOUT) && out_ready) ||
                     ((state_q == S_IDLE) && start && (cfg_timesteps == '0));
  end

  assign threshold_out = thr_q;
  assign timestep      = timestep_q;
  assign acc_clr_n     = acc_clr_n_q;
  assign array_en      = array_en_q;
  assign array_flush   = array_flush_q;
  assign spike_sample  = spike_sample_q;
  assign out_valid     = out_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_snn_timestep_controller.sv
// Self-checking bench: directed table, randomized runs against a cycle-arithmetic model, and mid-run reset.
module tb_snn_timestep_controller;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [4:0]  cfg_timesteps;
  logic [7:0]  cfg_compute_cycles;
  logic [15:0] cfg_threshold;
  logic [15:0] threshold_out;
  logic        acc_clr_n;
  logic        array_en;
  logic        array_flush;
  logic        spike_sample;
  logic [4:0]  timestep;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  snn_timestep_controller dut (
    .clk                (clk),
    .rstn               (rstn),
    .start              (start),
    .cfg_timesteps      (cfg_timesteps),
    .cfg_compute_cycles (cfg_compute_cycles),
    .cfg_threshold      (cfg_threshold),
    .threshold_out      (threshold_out),
    .acc_clr_n          (acc_clr_n),
    .array_en           (array_en),
    .array_flush        (array_flush),
    .spike_sample       (spike_sample),
    .timestep           (timestep),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .busy               (busy),
    .done               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          t;
    int          c;
    logic [15:0] thr;
    int          d;
    bit          junk;
    bit          early;
    int          exp_valid;
    int          exp_done;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Flag order: {acc_clr_n, array_en, array_flush, spike_sample, out_valid, busy, done}
  function automatic logic [6:0] dut_flags();
    return {acc_clr_n, array_en, array_flush, spike_sample, out_valid, busy, done};
  endfunction

  task automatic check_reset_values(input string name);
    check({name, "_flags"}, 0, 32'(dut_flags()), 32'(7'b1000000));
    check({name, "_thr"}, 0, 32'(threshold_out), 32'd0);
    check({name, "_ts"}, 0, 32'(timestep), 32'd0);
  endtask

  // The run is described purely by cycle arithmetic: period P = C'+2 per timestep after one CLEAR cycle.
  task automatic run_case(input int t, input int c, input logic [15:0] thr, input int d,
                          input bit junk, input bit early, input int exp_valid, input int exp_done);
    int ce, p, kr, last, first_valid, first_done, j, r, ets;
    bit clr, en, fl, smp, vld, bsy, dn, chk_ts;
    ce = (c == 0) ? 1 : c;
    p  = ce + 2;
    kr = (t == 0) ? 0 : t * p + 1;
    last = (t == 0) ? 3 : kr + d + 2;
    first_valid = 0;
    first_done  = 0;

    @(posedge clk); #1;
    start              = 1'b1;
    cfg_timesteps      = 5'(t);
    cfg_compute_cycles = 8'(c);
    cfg_threshold      = thr;
    out_ready          = early;

    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (junk && t != 0 && k <= kr + d) begin
        start              = 1'($urandom_range(0, 1));
        cfg_timesteps      = 5'($urandom);
        cfg_compute_cycles = 8'($urandom);
        cfg_threshold      = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      out_ready = (t != 0) && ((k < kr && early) || (k >= kr + d));
      @(negedge clk);

      clr = 0; en = 0; fl = 0; smp = 0; vld = 0; bsy = 0; dn = 0;
      chk_ts = 0; ets = 0;
      if (t == 0) begin
        dn = (k == 1);
      end else begin
        bsy = (k <= kr + d);
        vld = (k >= kr) && (k <= kr + d);
        dn  = (k == kr + d + 1);
        if (k == 1) begin
          clr = 1; chk_ts = 1; ets = 0;
        end else if (k < kr) begin
          j   = k - 2;
          r   = j % p;
          en  = (r < ce);
          smp = (r == ce);
          fl  = (r == ce + 1);
          chk_ts = (r <= ce);
          ets = j / p;
        end else if (vld) begin
          chk_ts = 1; ets = t - 1;
        end
      end

      check("flags", k, 32'(dut_flags()), 32'({~clr, en, fl, smp, vld, bsy, dn}));
      check("threshold", k, 32'(threshold_out), 32'(thr));
      if (chk_ts) check("timestep", k, 32'(timestep), 32'(ets));
      if (out_valid && first_valid == 0) first_valid = k;
      if (done && first_done == 0) first_done = k;
    end

    check("first_valid", 0, 32'(first_valid), 32'(exp_valid));
    check("first_done", 0, 32'(first_done), 32'(exp_done));
    $display("run T=%0d C=%0d thr=0x%04h ready_delay=%0d junk=%0d early=%0d valid@%0d done@%0d",
             t, c, thr, d, junk, early, first_valid, first_done);
  endtask

  initial begin
    int rt, rc, rd, rkr;
    bit rj, re;

    vecs[0] = '{t: 2,  c: 3,   thr: 16'd100,  d: 0,  junk: 0, early: 0, exp_valid: 11,  exp_done: 12};
    vecs[1] = '{t: 0,  c: 5,   thr: 16'h1234, d: 0,  junk: 0, early: 0, exp_valid: 0,   exp_done: 1};
    vecs[2] = '{t: 1,  c: 0,   thr: 16'hFF9C, d: 0,  junk: 0, early: 0, exp_valid: 4,   exp_done: 5};
    vecs[3] = '{t: 3,  c: 2,   thr: 16'd77,   d: 20, junk: 0, early: 0, exp_valid: 13,  exp_done: 34};
    vecs[4] = '{t: 31, c: 1,   thr: 16'h7FFF, d: 0,  junk: 0, early: 0, exp_valid: 94,  exp_done: 95};
    vecs[5] = '{t: 1,  c: 255, thr: 16'h8000, d: 0,  junk: 0, early: 0, exp_valid: 258, exp_done: 259};
    vecs[6] = '{t: 4,  c: 7,   thr: 16'd55,   d: 3,  junk: 1, early: 1, exp_valid: 37,  exp_done: 41};
    vecs[7] = '{t: 2,  c: 3,   thr: 16'd100,  d: 2,  junk: 1, early: 0, exp_valid: 11,  exp_done: 14};

    rstn = 1'b0;
    start = 1'b0;
    cfg_timesteps = '0;
    cfg_compute_cycles = '0;
    cfg_threshold = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    foreach (vecs[i]) begin
      run_case(vecs[i].t, vecs[i].c, vecs[i].thr, vecs[i].d, vecs[i].junk, vecs[i].early,
               vecs[i].exp_valid, vecs[i].exp_done);
    end

    for (int n = 0; n < 20; n++) begin
      rt = $urandom_range(0, 6);
      rc = $urandom_range(0, 6);
      rd = $urandom_range(0, 4);
      rj = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      rkr = (rt == 0) ? 0 : rt * (((rc == 0) ? 1 : rc) + 2) + 1;
      run_case(rt, rc, 16'($urandom), rd, rj, re, rkr, (rt == 0) ? 1 : rkr + rd + 1);
    end

    // Mid-run reset: T=4 run started in cycle 0, rstn dropped inside cycle 5.
    @(posedge clk); #1;
    start = 1'b1;
    cfg_timesteps = 5'd4;
    cfg_compute_cycles = 8'd2;
    cfg_threshold = 16'd999;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("midrun_busy_before_reset", 5, 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check_reset_values("async_reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_reset_values("after_reset");
    $display("run mid-run reset T=4 C=2 interrupted in cycle 5");
    run_case(2, 3, 16'd321, 0, 0, 0, 11, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
